aes128_key_sched_ctrl: RTL and testbench
========================================

Name: aes128_key_sched_ctrl

Overview:
Sequencer and round-key cache for aes128_key_expansion. On a key-load request it captures the 128-bit cipher key and drives the expansion core through rounds 0..9, one per cycle. It stores K0..K10 in an internal 11-entry register file. Cipher/decipher engines then read any round key by index, in any order; decryption reads K10 down to K0.

Parameters:
NR, 10, number of AES rounds (only 10 supported; slots = NR+1)
IDX_W, 4, width of round-key index

Ports:
clk_sys  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
key_load  input  1  pulse: latch cipher_key and start expansion
cipher_key  input  128  user cipher key, sampled when key_load accepted
key_clear  input  1  pulse: zeroize key cache
rk_req  input  1  round-key read request
rk_idx  input  IDX_W  requested round-key index 0..NR
kexp_rkey_en  output  1  enable to expansion core (drives its rkey_en; cipher_en tied 0 externally)
kexp_round_num  output  4  round_num to expansion core
kexp_cipher_key  output  128  latched cipher key to expansion core
kexp_round_key  input  128  round_key_out from expansion core
busy  output  1  expansion in progress
keys_valid  output  1  all NR+1 slots hold keys of the current cipher key
load_drop  output  1  pulse: key_load ignored because busy
rk_ack  output  1  pulse, one cycle after rk_req
rk_err  output  1  qualifies rk_ack: bad index or keys not valid
rk_data  output  128  round key, valid with rk_ack

Behaviour:
- Reset: state IDLE; busy=0, keys_valid=0, load_drop=0, rk_ack=0, rk_err=0, rk_data=0, kexp_rkey_en=0, kexp_round_num=0, kexp_cipher_key=0, cnt=0, all slots zero.
- FSM states: IDLE, EXPAND, DONE.
- IDLE/DONE + key_load (cycle 0):
  - kexp_cipher_key and slot0 <= cipher_key.
  - keys_valid <= 0, cnt <= 0, go EXPAND.
- EXPAND, cycles 1..10:
  - busy=1, kexp_rkey_en=1, kexp_round_num=cnt (combinational from cnt), cnt++.
  - One-cycle write pipeline: wr_v/wr_slot register (cnt+1) when en is issued.
  - The cycle after each issue, slot[wr_slot] <= kexp_round_key; writes slots 1..10 in cycles 2..11.
  - After the issue with cnt=9, go DONE.
- DONE entry: busy stays 1 through cycle 11 (final write); keys_valid=1 from cycle 12. Total latency key_load to keys_valid = 12 cycles.
- key_load while busy: ignored, load_drop=1 for one cycle, sequence continues unaffected.
- key_load in DONE: restart; keys_valid drops the next cycle.
- key_clear, any state: next cycle all slots=0, kexp_cipher_key=0, keys_valid=0, busy=0, state IDLE, pending write cancelled. key_clear has priority over a simultaneous key_load (the load is dropped silently).
- Read port:
  - rk_req sampled in cycle t gives rk_ack=1 at t+1.
  - If rk_idx>NR or keys_valid==0 at t: rk_err=1, rk_data=0.
  - Else: rk_err=0, rk_data=slot[rk_idx] as of t, before any same-edge write. So a read coincident with key_load returns old data, then keys_valid falls.
  - Back-to-back requests are accepted every cycle. rk_data holds its last value while rk_ack=0.
- kexp_rkey_en is never asserted outside EXPAND.
- rst_n assertion mid-expansion returns everything to reset values immediately.

Test Plan:
- Reset, then key_load with key 2b7e151628aed2a6abf7158809cf4f3c -> kexp_round_num 0..9 in cycles 1..10; busy cycles 1..11; keys_valid rises at cycle 12.
- After load, read idx 0,1,10 back-to-back -> 2b7e1516..., a0fafe1788542cb123a339392a6c7605, d014f9a8c9ee2589e13f0cc8b6630ca6; rk_err=0 each; acks on consecutive cycles.
- Read idx 11 and 15 -> rk_ack=1, rk_err=1, rk_data=0; read before first load -> rk_err=1.
- key_load at cycle 5 of expansion -> load_drop pulse; keys identical to the uninterrupted run. Reload in DONE with key 0 -> K10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- key_clear mid-expansion (cycle 6) -> next cycle busy=0, keys_valid=0, slot reads give rk_err; no further kexp_rkey_en.
- rst_n low at cycle 4 -> all outputs at reset values asynchronously; a fresh load then completes normally.

Source files
------------

// File: rtl/aes128_key_sched_ctrl.sv
// rtl/aes128_key_sched_ctrl.sv - AES-128 key-expansion sequencer and 11-entry round-key cache
module aes128_key_sched_ctrl #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic [127:0]     cipher_key,
    input  logic             key_clear,
    input  logic             rk_req,
    input  logic [IDX_W-1:0] rk_idx,
    output logic             kexp_rkey_en,
    output logic [3:0]       kexp_round_num,
    output logic [127:0]     kexp_cipher_key,
    input  logic [127:0]     kexp_round_key,
    output logic             busy,
    output logic             keys_valid,
    output logic             load_drop,
    output logic             rk_ack,
    output logic             rk_err,
    output logic [127:0]     rk_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

    localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(NR);
    localparam logic [3:0]       LP_LAST_CNT = 4'(NR - 1);
    localparam logic [3:0]       LP_LAST_SLOT = 4'(NR);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_wr_v;
    logic [3:0]       r_wr_slot;
    logic [127:0]     r_slot [0:NR];
    logic [127:0]     r_cipher_key;
    logic             r_keys_valid;
    logic             r_load_drop;
    logic             r_rk_ack;
    logic             r_rk_err;
    logic [127:0]     r_rk_data;

    logic             w_busy;
    logic             w_load_ok;
    logic             w_rd_ok;
    logic [IDX_W-1:0] w_rd_idx;

    // Busy covers the expansion cycles plus the trailing write of the last slot.
    assign w_busy    = (r_state == ST_EXPAND) | r_wr_v;
    assign w_load_ok = key_load & ~key_clear & ~w_busy;
    assign w_rd_ok   = (rk_idx <= LP_LAST_IDX) & r_keys_valid;
    assign w_rd_idx  = w_rd_ok ? rk_idx : '0;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_wr_v       <= 1'b0;
            r_wr_slot    <= '0;
            r_cipher_key <= '0;
            r_keys_valid <= 1'b0;
            r_load_drop  <= 1'b0;
            r_rk_ack     <= 1'b0;
            r_rk_err     <= 1'b0;
            r_rk_data    <= '0;
            for (int i = 0; i <= NR; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_load_drop <= key_load & ~key_clear & w_busy;
            r_rk_ack    <= rk_req;
            if (rk_req) begin
                r_rk_err  <= ~w_rd_ok;
                r_rk_data <= w_rd_ok ? r_slot[w_rd_idx] : '0;
            end else begin
                r_rk_err  <= 1'b0;
            end

            if (key_clear) begin
                r_state      <= ST_IDLE;
                r_cnt        <= '0;
                r_wr_v       <= 1'b0;
                r_wr_slot    <= '0;
                r_cipher_key <= '0;
                r_keys_valid <= 1'b0;
                for (int i = 0; i <= NR; i++) begin
                    r_slot[i] <= '0;
                end
            end else begin
                r_wr_v <= 1'b0;
                // The core returns the round key one cycle after each enable.
                if (r_wr_v) begin
                    r_slot[r_wr_slot] <= kexp_round_key;
                    if (r_wr_slot == LP_LAST_SLOT) begin
                        r_keys_valid <= 1'b1;
                    end
                end
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (w_load_ok) begin
                            r_cipher_key <= cipher_key;
                            r_slot[0]    <= cipher_key;
                            r_keys_valid <= 1'b0;
                            r_cnt        <= '0;
                            r_state      <= ST_EXPAND;
                        end
                    end
                    ST_EXPAND: begin
                        r_cnt     <= r_cnt + 4'd1;
                        r_wr_v    <= 1'b1;
                        r_wr_slot <= r_cnt + 4'd1;
                        if (r_cnt == LP_LAST_CNT) begin
                            r_state <= ST_DONE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign kexp_rkey_en    = (r_state == ST_EXPAND);
    assign kexp_round_num  = r_cnt;
    assign kexp_cipher_key = r_cipher_key;
    assign busy            = w_busy;
    assign keys_valid      = r_keys_valid;
    assign load_drop       = r_load_drop;
    assign rk_ack          = r_rk_ack;
    assign rk_err          = r_rk_err;
    assign rk_data         = r_rk_data;

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// tb/tb_aes128_key_sched_ctrl.sv - scoreboard bench for aes128_key_sched_ctrl with AES key-schedule model
module tb_aes128_key_sched_ctrl;

    localparam int NR = 10;

    logic         clk_sys = 1'b0;
    logic         rst_n;
    logic         key_load;
    logic [127:0] cipher_key;
    logic         key_clear;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         kexp_rkey_en;
    logic [3:0]   kexp_round_num;
    logic [127:0] kexp_cipher_key;
    logic [127:0] kexp_round_key = '0;
    logic         busy;
    logic         keys_valid;
    logic         load_drop;
    logic         rk_ack;
    logic         rk_err;
    logic [127:0] rk_data;

    always #5 clk_sys = ~clk_sys;

    aes128_key_sched_ctrl #(.NR(NR), .IDX_W(4)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .key_load(key_load), .cipher_key(cipher_key),
        .key_clear(key_clear), .rk_req(rk_req), .rk_idx(rk_idx),
        .kexp_rkey_en(kexp_rkey_en), .kexp_round_num(kexp_round_num),
        .kexp_cipher_key(kexp_cipher_key), .kexp_round_key(kexp_round_key),
        .busy(busy), .keys_valid(keys_valid), .load_drop(load_drop),
        .rk_ack(rk_ack), .rk_err(rk_err), .rk_data(rk_data)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sbox [0:255];

    typedef struct {
        logic         err;
        logic [127:0] data;
        string        name;
    } exp_t;
    exp_t sb_q[$];

    logic         m_valid = 1'b0;
    logic [127:0] m_key   = '0;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    // Textbook FIPS-197 key schedule on 32-bit words.
    function automatic logic [127:0] ref_rk(input logic [127:0] key, input int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        if (r < 0 || r > NR) return '0;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Expansion core stand-in: round key r+1 appears the cycle after enable with round_num r.
    always @(posedge clk_sys) begin
        if (kexp_rkey_en) kexp_round_key <= ref_rk(kexp_cipher_key, int'(kexp_round_num) + 1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        exp_t e;
        if (rst_n === 1'b1 && rk_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: got rk_ack=1 want no ack");
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_err"}, 128'(rk_err), 128'(e.err));
                chk({e.name, "_data"}, rk_data, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic read_exp(input int idx, input logic err, input logic [127:0] data, input string nm);
        exp_t e;
        rk_req = 1'b1;
        rk_idx = 4'(idx);
        e.err  = err;
        e.data = data;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic read_model(input int idx, input string nm);
        if (idx > NR || !m_valid) read_exp(idx, 1'b1, '0, nm);
        else                      read_exp(idx, 1'b0, ref_rk(m_key, idx), nm);
    endtask

    task automatic load(input logic [127:0] key);
        key_load   = 1'b1;
        cipher_key = key;
        step();
        key_load   = 1'b0;
        m_key      = key;
        m_valid    = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        while (keys_valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk({nm, "_valid_rise"}, 128'(keys_valid), 128'(1));
        m_valid = 1'b1;
    endtask

    task automatic rd_burst(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) rk_req = 1'b0;
            else read_model(int'($urandom_range(0, 15)), nm);
            step();
        end
        rk_req = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [127:0] key_a;
        int           k;
        int           en_seen;
        rst_n = 1'b0; key_load = 1'b0; cipher_key = '0; key_clear = 1'b0;
        rk_req = 1'b0; rk_idx = '0;
        build_sbox();
        step(); step();

        chk("rst_busy", 128'(busy), 0);
        chk("rst_keys_valid", 128'(keys_valid), 0);
        chk("rst_load_drop", 128'(load_drop), 0);
        chk("rst_rk_ack", 128'(rk_ack), 0);
        chk("rst_rk_data", rk_data, 0);
        chk("rst_rkey_en", 128'(kexp_rkey_en), 0);
        chk("rst_round_num", 128'(kexp_round_num), 0);
        chk("rst_cipher_key", kexp_cipher_key, 0);
        rst_n = 1'b1;
        step();

        read_exp(3, 1'b1, '0, "rd_before_load");
        step();
        rk_req = 1'b0;
        step(); step();

        load(FIPS_KEY);
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("c%0d_rkey_en", c), 128'(kexp_rkey_en), 128'(c <= 10));
            if (c <= 10) chk($sformatf("c%0d_round_num", c), 128'(kexp_round_num), 128'(c - 1));
            chk($sformatf("c%0d_busy", c), 128'(busy), 128'(c <= 11));
            chk($sformatf("c%0d_keys_valid", c), 128'(keys_valid), 128'(c >= 12));
            if (c == 1) chk("c1_cipher_key", kexp_cipher_key, FIPS_KEY);
            if (c < 12) step();
        end
        m_valid = 1'b1;

        read_exp(0, 1'b0, FIPS_KEY, "fips_k0"); step();
        read_exp(1, 1'b0, FIPS_K1, "fips_k1"); step();
        read_exp(10, 1'b0, FIPS_K10, "fips_k10"); step();
        read_exp(11, 1'b1, '0, "idx11"); step();
        read_exp(15, 1'b1, '0, "idx15"); step();
        rk_req = 1'b0;
        step(); step();

        for (int it = 0; it < 4; it++) begin
            key_a = {$urandom, $urandom, $urandom, $urandom};
            load(key_a);
            k = int'($urandom_range(2, 9));
            for (int j = 1; j < k; j++) step();
            key_load   = 1'b1;
            cipher_key = {$urandom, $urandom, $urandom, $urandom};
            step();
            key_load = 1'b0;
            chk($sformatf("it%0d_load_drop", it), 128'(load_drop), 1);
            step();
            chk($sformatf("it%0d_load_drop_off", it), 128'(load_drop), 0);
            wait_valid($sformatf("it%0d", it));
            chk($sformatf("it%0d_key_kept", it), kexp_cipher_key, key_a);
            rd_burst(14, $sformatf("it%0d_rd", it));
        end

        read_model(10, "coincident_old");
        load(128'h0);
        rk_req = 1'b0;
        chk("reload_valid_fall", 128'(keys_valid), 0);
        wait_valid("reload_zero");
        read_exp(10, 1'b0, ZERO_K10, "zero_k10");
        step();
        rk_req = 1'b0;
        step(); step();

        load({$urandom, $urandom, $urandom, $urandom});
        for (int j = 1; j < 6; j++) step();
        key_clear = 1'b1;
        step();
        key_clear = 1'b0;
        m_valid = 1'b0;
        chk("clr_busy", 128'(busy), 0);
        chk("clr_keys_valid", 128'(keys_valid), 0);
        chk("clr_cipher_key", kexp_cipher_key, 0);
        en_seen = 0;
        for (int j = 0; j < 6; j++) begin
            if (kexp_rkey_en === 1'b1) en_seen++;
            read_model(int'($urandom_range(0, 10)), "clr_rd");
            step();
        end
        rk_req = 1'b0;
        chk("clr_no_rkey_en", 128'(en_seen), 0);
        step(); step();

        key_load = 1'b1; key_clear = 1'b1; cipher_key = FIPS_KEY;
        step();
        key_load = 1'b0; key_clear = 1'b0;
        chk("clr_load_busy", 128'(busy), 0);
        chk("clr_load_drop", 128'(load_drop), 0);
        step();
        chk("clr_load_idle_en", 128'(kexp_rkey_en), 0);

        load({$urandom, $urandom, $urandom, $urandom});
        for (int j = 1; j < 4; j++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 128'(busy), 0);
        chk("arst_rkey_en", 128'(kexp_rkey_en), 0);
        chk("arst_round_num", 128'(kexp_round_num), 0);
        chk("arst_cipher_key", kexp_cipher_key, 0);
        chk("arst_keys_valid", 128'(keys_valid), 0);
        m_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        key_a = {$urandom, $urandom, $urandom, $urandom};
        load(key_a);
        wait_valid("post_rst");
        read_model(10, "post_rst_k10");
        step();
        rk_req = 1'b0;
        rd_burst(12, "post_rst_rd");

        step(); step();
        chk("sb_empty", 128'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
